// File: rtl/pwm_timebase.sv
// PWM timebase counter: linear prescaler, up / down / centre-aligned
// up-down counting, shadowed period/prescale/mode reloaded on update events,
// optional one-shot stop, and registered overflow/underflow/update strobes.
module pwm_timebase #(
   parameter int CNT_W = 16,
   parameter int PSC_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             count_reset,
   input  logic [1:0]       mode,
   input  logic             one_shot,
   input  logic [CNT_W-1:0] period,
   input  logic [PSC_W-1:0] prescale,
   output logic [CNT_W-1:0] count_val,
   output logic             dir,
   output logic             ovf,
   output logic             unf,
   output logic             upd,
   output logic             running
);

   typedef enum logic [1:0] {
      MODE_UP   = 2'b00,
      MODE_DOWN = 2'b01,
      MODE_UPDN = 2'b10,
      MODE_RSVD = 2'b11   // treated as up
   } mode_e;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_shd_period;
   logic [PSC_W-1:0] r_psc_cnt;
   logic [PSC_W-1:0] r_shd_prescale;
   mode_e            r_shd_mode;
   logic             r_dir;
   logic             r_done;
   logic             r_ovf;
   logic             r_unf;
   logic             r_upd;
   logic             r_running;

   logic             w_tick;
   logic [CNT_W-1:0] w_count_nxt;
   logic             w_dir_nxt;
   logic             w_ovf_nxt;
   logic             w_unf_nxt;
   logic             w_upd_nxt;

   // A tick fires when the prescaler reaches the shadowed divisor minus one.
   assign w_tick = en & ~r_done & (r_psc_cnt == r_shd_prescale);

   // Count, direction and strobes that a tick would produce in the shadowed mode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      w_count_nxt = r_count;
      w_dir_nxt   = r_dir;
      w_ovf_nxt   = 1'b0;
      w_unf_nxt   = 1'b0;
      w_upd_nxt   = 1'b0;
      case (r_shd_mode)
         MODE_DOWN: begin
            w_dir_nxt = 1'b0;
            if (r_count == '0) begin
               // Reload uses the live period input, which is also being
               // latched into the shadow on this same update edge.
               w_count_nxt = period;
               w_unf_nxt   = 1'b1;
               w_upd_nxt   = 1'b1;
            end else begin
               w_count_nxt = r_count - CNT_ONE;
            end
         end
         MODE_UPDN: begin
            if (r_shd_period == '0) begin
               // Degenerate period: stay parked at zero, one update per tick.
               w_count_nxt = '0;
               w_dir_nxt   = 1'b1;
               w_unf_nxt   = 1'b1;
               w_upd_nxt   = 1'b1;
            end else if (r_dir && (r_count >= r_shd_period)) begin
               w_dir_nxt   = 1'b0;
               w_count_nxt = r_count - CNT_ONE;
               w_ovf_nxt   = 1'b1;
            end else if (!r_dir && (r_count == '0)) begin
               w_dir_nxt   = 1'b1;
               w_count_nxt = r_count + CNT_ONE;
               w_unf_nxt   = 1'b1;
               w_upd_nxt   = 1'b1;
            end else if (r_dir) begin
               w_count_nxt = r_count + CNT_ONE;
            end else begin
               w_count_nxt = r_count - CNT_ONE;
            end
         end
         default: begin
            // Up mode and the reserved encoding.
            w_dir_nxt = 1'b1;
            if (r_count >= r_shd_period) begin
               w_count_nxt = '0;
               w_ovf_nxt   = 1'b1;
               w_upd_nxt   = 1'b1;
            end else begin
               w_count_nxt = r_count + CNT_ONE;
            end
         end
      endcase
   end

   // State register: reset, counter clear, stopped, one-shot done and counting.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         r_count        <= '0;
         r_dir          <= 1'b1;
         r_psc_cnt      <= '0;
         r_done         <= 1'b0;
         r_ovf          <= 1'b0;
         r_unf          <= 1'b0;
         r_upd          <= 1'b0;
         r_running      <= 1'b0;
         r_shd_period   <= '0;
         r_shd_prescale <= '0;
         r_shd_mode     <= MODE_UP;
      end else begin
         r_running <= en & ~r_done;
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
         r_upd     <= 1'b0;
         if (count_reset || !en) begin
            // Cleared or stopped: shadows are transparent, prescaler idles.
            if (count_reset) begin
               r_count <= '0;
               r_dir   <= 1'b1;
            end
            r_psc_cnt      <= '0;
            r_done         <= 1'b0;
            r_shd_period   <= period;
            r_shd_prescale <= prescale;
            r_shd_mode     <= mode_e'(mode);
         end else if (!r_done) begin
            if (w_tick) begin
               r_psc_cnt <= '0;
               r_count   <= w_count_nxt;
               r_dir     <= w_dir_nxt;
               r_ovf     <= w_ovf_nxt;
               r_unf     <= w_unf_nxt;
               r_upd     <= w_upd_nxt;
               if (w_upd_nxt) begin
                  r_shd_period   <= period;
                  r_shd_prescale <= prescale;
                  r_shd_mode     <= mode_e'(mode);
                  r_done         <= one_shot;
               end
            end else begin
               r_psc_cnt <= r_psc_cnt + PSC_ONE;
            end
         end
      end
   end

   assign count_val = r_count;
   assign dir       = r_dir;
   assign ovf       = r_ovf;
   assign unf       = r_unf;
   assign upd       = r_upd;
   assign running   = r_running;

endmodule

// File: tb/tb_pwm_timebase.sv
// Directed testbench for pwm_timebase. Each test task drives its own vectors
// and compares {count_val, dir, ovf, unf, upd} against hand-computed tables.
// Outputs are sampled 1 ns after the rising edge; inputs change at that point.
module tb_pwm_timebase;

   localparam int CNT_W = 16;
   localparam int PSC_W = 8;
   localparam int VW    = CNT_W + 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             count_reset;
   logic [1:0]       mode;
   logic             one_shot;
   logic [CNT_W-1:0] period;
   logic [PSC_W-1:0] prescale;
   logic [CNT_W-1:0] count_val;
   logic             dir;
   logic             ovf;
   logic             unf;
   logic             upd;
   logic             running;

   int checks   = 0;
   int failures = 0;

   logic [VW-1:0] got;
   logic [VW-1:0] want;

   pwm_timebase #(.CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .count_reset (count_reset),
      .mode        (mode),
      .one_shot    (one_shot),
      .period      (period),
      .prescale    (prescale),
      .count_val   (count_val),
      .dir         (dir),
      .ovf         (ovf),
      .unf         (unf),
      .upd         (upd),
      .running     (running)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // Advance one clock; outputs are stable at return.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Load a configuration through count_reset, then enable counting.
   task automatic start(input logic [1:0] m, input int p, input int ps, input logic os);
      mode        = m;
      period      = CNT_W'(p);
      prescale    = PSC_W'(ps);
      one_shot    = os;
      en          = 1'b0;
      count_reset = 1'b1;
      step();
      count_reset = 1'b0;
      en          = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; count_reset = 1'b0; mode = 2'b00;
      one_shot = 1'b0; period = 16'd5; prescale = 8'd0;
      step();
      step();
      got  = {count_val, dir, ovf, unf, upd};
      want = {16'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL reset_outputs: got=%h want=%h (cnt|dir,ovf,unf,upd)", got, want);
      end
      checks++;
      if (running !== 1'b0) begin
         failures++;
         $display("FAIL reset_running: got=%b want=0", running);
      end
      rst_n = 1'b1; en = 1'b0;
      step();
   endtask

   task automatic test_up();
      int e_cnt[6] = '{1, 2, 3, 0, 1, 2};
      bit e_ovf[6] = '{0, 0, 0, 1, 0, 0};
      start(2'b00, 3, 0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step();
         got  = {count_val, dir, ovf, unf, upd};
         want = {CNT_W'(e_cnt[i]), 1'b1, e_ovf[i], 1'b0, e_ovf[i]};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL up[%0d]: got=%h want=%h (cnt|dir,ovf,unf,upd)", i, got, want);
         end
         if (i == 0) begin
            checks++;
            if (running !== 1'b1) begin
               failures++;
               $display("FAIL up_running: got=%b want=1", running);
            end
         end
      end
   endtask

   task automatic test_prescale();
      int e_cnt[12] = '{0, 0, 1, 1, 1, 2, 2, 2, 0, 0, 0, 1};
      bit e_ovf[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      start(2'b00, 2, 2, 1'b0);
      for (int i = 0; i < 12; i++) begin
         step();
         got  = {count_val, dir, ovf, unf, upd};
         want = {CNT_W'(e_cnt[i]), 1'b1, e_ovf[i], 1'b0, e_ovf[i]};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL prescale[%0d]: got=%h want=%h (cnt|dir,ovf,unf,upd)", i, got, want);
         end
      end
   endtask

   task automatic test_down();
      int e_cnt[12] = '{4, 3, 2, 1, 0, 4, 3, 2, 1, 0, 6, 5};
      bit e_unf[12] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
      start(2'b01, 4, 0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         if (i == 7) period = 16'd6;
         step();
         got  = {count_val, dir, ovf, unf, upd};
         want = {CNT_W'(e_cnt[i]), 1'b0, 1'b0, e_unf[i], e_unf[i]};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL down[%0d]: got=%h want=%h (cnt|dir,ovf,unf,upd)", i, got, want);
         end
      end
   endtask

   task automatic test_updown();
      int e_cnt[10] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
      bit e_dir[10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
      bit e_ovf[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
      bit e_unf[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      start(2'b10, 3, 0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step();
         got  = {count_val, dir, ovf, unf, upd};
         want = {CNT_W'(e_cnt[i]), e_dir[i], e_ovf[i], e_unf[i], e_unf[i]};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL updown[%0d]: got=%h want=%h (cnt|dir,ovf,unf,upd)", i, got, want);
         end
      end
      // Zero period: parked at 0, underflow and update on every tick.
      start(2'b10, 0, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         got  = {count_val, dir, ovf, unf, upd};
         want = {16'd0, 1'b1, 1'b0, 1'b1, 1'b1};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL updown_p0[%0d]: got=%h want=%h (cnt|dir,ovf,unf,upd)", i, got, want);
         end
      end
   endtask

   task automatic test_shadow();
      int e_cnt[6] = '{1, 2, 3, 0, 5, 4};
      bit e_dir[6] = '{1, 1, 1, 1, 0, 0};
      bit e_ovf[6] = '{0, 0, 0, 1, 0, 0};
      bit e_unf[6] = '{0, 0, 0, 0, 1, 0};
      bit e_upd[6] = '{0, 0, 0, 1, 1, 0};
      start(2'b00, 3, 0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         if (i == 1) begin
            period = 16'd5;
            mode   = 2'b01;
         end
         step();
         got  = {count_val, dir, ovf, unf, upd};
         want = {CNT_W'(e_cnt[i]), e_dir[i], e_ovf[i], e_unf[i], e_upd[i]};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL shadow[%0d]: got=%h want=%h (cnt|dir,ovf,unf,upd)", i, got, want);
         end
      end
   endtask

   task automatic test_one_shot();
      int e_cnt[5] = '{1, 2, 0, 0, 0};
      bit e_ovf[5] = '{0, 0, 1, 0, 0};
      start(2'b00, 2, 0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         got  = {count_val, dir, ovf, unf, upd};
         want = {CNT_W'(e_cnt[i]), 1'b1, e_ovf[i], 1'b0, e_ovf[i]};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL one_shot[%0d]: got=%h want=%h (cnt|dir,ovf,unf,upd)", i, got, want);
         end
      end
      checks++;
      if (running !== 1'b0) begin
         failures++;
         $display("FAIL one_shot_running_low: got=%b want=0", running);
      end
      // Toggle en to clear the done flag and restart.
      en = 1'b0;
      step();
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         got  = {count_val, dir, ovf, unf, upd};
         want = {CNT_W'(e_cnt[i]), 1'b1, e_ovf[i], 1'b0, e_ovf[i]};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL one_shot_restart[%0d]: got=%h want=%h (cnt|dir,ovf,unf,upd)", i, got, want);
         end
      end
      checks++;
      if (running !== 1'b1) begin
         failures++;
         $display("FAIL one_shot_running_restart: got=%b want=1", running);
      end
      one_shot = 1'b0;
   endtask

   task automatic test_count_reset();
      start(2'b00, 9, 0, 1'b0);
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (count_val !== 16'd5) begin
         failures++;
         $display("FAIL creset_pre: got=%0d want=5", count_val);
      end
      count_reset = 1'b1;
      step();
      got  = {count_val, dir, ovf, unf, upd};
      want = {16'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL creset_clear: got=%h want=%h (cnt|dir,ovf,unf,upd)", got, want);
      end
      count_reset = 1'b0;
      step();
      got  = {count_val, dir, ovf, unf, upd};
      want = {16'd1, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL creset_resume: got=%h want=%h (cnt|dir,ovf,unf,upd)", got, want);
      end
   endtask

   task automatic test_reset_mid_count();
      start(2'b00, 3, 0, 1'b0);
      step();
      step();
      rst_n = 1'b0;
      step();
      got  = {count_val, dir, ovf, unf, upd};
      want = {16'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (got !== want || running !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid: got=%h run=%b want=%h run=0 (cnt|dir,ovf,unf,upd)", got, running, want);
      end
      // Shadows were cleared, so the first enabled tick sees period 0 and wraps.
      rst_n = 1'b1;
      step();
      got  = {count_val, dir, ovf, unf, upd};
      want = {16'd0, 1'b1, 1'b1, 1'b0, 1'b1};
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL rst_shadow_zero: got=%h want=%h (cnt|dir,ovf,unf,upd)", got, want);
      end
      step();
      got  = {count_val, dir, ovf, unf, upd};
      want = {16'd1, 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL rst_shadow_reload: got=%h want=%h (cnt|dir,ovf,unf,upd)", got, want);
      end
   endtask

   initial begin
      test_reset();
      test_up();
      test_prescale();
      test_down();
      test_updown();
      test_shadow();
      test_one_shot();
      test_count_reset();
      test_reset_mid_count();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
